// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and address-split helpers for dcache_assoc
//
// Purpose: controller state encoding plus constant functions that derive the
// offset/index/way-select field widths from the cache geometry.
// Ports: none (package).

package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WBACK = 2'd1,
        FILL  = 2'd2,
        OPWB  = 2'd3
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Byte-offset field: word-in-line bits plus the two byte bits.
    function automatic int off_bits(input int line_words);
        return clog2(line_words) + 2;
    endfunction

    function automatic int idx_bits(input int sets);
        return clog2(sets);
    endfunction

    // Zero for a direct-mapped configuration.
    function automatic int way_bits(input int ways);
        return clog2(ways);
    endfunction

endpackage

// File: rtl/dcache_way.sv
// rtl/dcache_way.sv - one way of the set-associative data cache
//
// Purpose: valid/dirty/tag/data storage for a single way. Reads are
// asynchronous at (idx, word); writes happen on the rising edge.
// Ports:
//   clk, rst                 clock, synchronous active-low reset (valid/dirty only)
//   idx, word, tag           set index, word-in-line, compare/allocate tag
//   hit, rdata               tag match with valid line, word at (idx, word)
//   line_valid/dirty/tag     state of the line at idx
//   fill_we, fill_data       write a whole word (line fill beat)
//   merge_we, wmask, wdata   byte-merge store, marks the line dirty
//   alloc                    mark line valid+clean and write tag
//   inv                      clear valid and dirty

module dcache_way #(
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4,
    parameter int TW         = 20,
    parameter int IW         = 8,
    parameter int WO         = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] idx,
    input  logic [WO-1:0] word,
    input  logic [TW-1:0] tag,
    output logic          hit,
    output logic [31:0]   rdata,
    output logic          line_valid,
    output logic          line_dirty,
    output logic [TW-1:0] line_tag,
    input  logic          fill_we,
    input  logic [31:0]   fill_data,
    input  logic          merge_we,
    input  logic [3:0]    wmask,
    input  logic [31:0]   wdata,
    input  logic          alloc,
    input  logic          inv
);

    logic [SETS-1:0] valid;
    logic [SETS-1:0] dirty;
    logic [TW-1:0]   tags [SETS];
    logic [31:0]     data [SETS][LINE_WORDS];

    assign line_valid = valid[idx];
    assign line_dirty = dirty[idx];
    assign line_tag   = tags[idx];
    assign rdata      = data[idx][word];
    assign hit        = valid[idx] && (tags[idx] == tag);

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (alloc) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
            if (inv) begin
                valid[idx] <= 1'b0;
                dirty[idx] <= 1'b0;
            end
            if (merge_we) dirty[idx] <= 1'b1;
        end
    end

    // Tag and data contents survive reset; only the valid bits guard them.
    always_ff @(posedge clk) begin
        if (fill_we) data[idx][word] <= fill_data;
        if (merge_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) data[idx][word][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (alloc) tags[idx] <= tag;
    end

endmodule

// File: rtl/dcache_assoc.sv
// rtl/dcache_assoc.sv - N-way set-associative write-back data cache (MEM stage)
//
// Purpose: write-allocate cache with per-set round-robin replacement,
// dirty-victim write-back and the index-writeback-invalidate op.
// Optional macro DCACHE_STATS_EN: saturating hit/miss counters; without it
// hit_cnt/miss_cnt are tied to zero.
// Ports:
//   clk, rst                         clock, synchronous active-low reset
//   d_r, d_w, d_wmask, d_addr,
//   d_wdata, d_rdata, ready          load/store port; ready=0 stalls the pipe
//   op_inv, op_addr                  index-writeback-invalidate request
//   mem_r, mem_w, mem_addr,
//   mem_wdata, mem_rdata, mem_ready  burst bus, one word per beat
//   cache_err                        illegal-request pulse
//   hit_cnt, miss_cnt                statistics

module dcache_assoc
    import cache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_r,
    input  logic        d_w,
    input  logic [3:0]  d_wmask,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        ready,
    input  logic        op_inv,
    input  logic [31:0] op_addr,
    output logic        mem_r,
    output logic        mem_w,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        cache_err,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int OFF = off_bits(LINE_WORDS);
    localparam int IDX = idx_bits(SETS);
    localparam int WB  = way_bits(WAYS);
    localparam int WS  = (WB > 0) ? WB : 1;
    localparam int WO  = OFF - 2;
    localparam int TW  = 32 - OFF - IDX;
    localparam logic [WO-1:0] LAST = WO'(LINE_WORDS - 1);

    state_t        state, state_n;
    logic [WO-1:0]  beat, beat_n;
    logic [TW-1:0]  lat_tag, lat_tag_n;
    logic [IDX-1:0] lat_idx, lat_idx_n;
    logic [WS-1:0]  victim, victim_n;
    logic [WS-1:0]  rr [SETS];
    logic           rr_we;
    logic [WS-1:0]  rr_adv;

    logic [TW-1:0]  req_tag;
    logic [IDX-1:0] req_idx, op_idx, cur_idx;
    logic [WO-1:0]  req_word, cur_word;
    logic [TW-1:0]  cmp_tag;
    logic [WS-1:0]  op_way, hit_way, vic_pick;
    logic           vic_found, any_hit, hit_evt, miss_evt;
    logic [31:0]    hit_word;

    logic [WAYS-1:0] w_hit, w_valid, w_dirty;
    logic [WAYS-1:0] fill_we, merge_we, alloc, inv;
    logic [31:0]     w_rdata [WAYS];
    logic [TW-1:0]   w_tag [WAYS];
    logic            unused_addr;

    assign req_tag  = d_addr[31:OFF+IDX];
    assign req_idx  = d_addr[OFF+IDX-1:OFF];
    assign req_word = d_addr[OFF-1:2];
    assign op_idx   = op_addr[OFF+IDX-1:OFF];
    assign op_way   = (WB > 0) ? op_addr[OFF+IDX +: WS] : '0;
    assign unused_addr = ^{d_addr[1:0], op_addr};

    // In IDLE the arrays are addressed by the incoming request (or op);
    // during a burst they follow the latched set and the beat counter.
    assign cur_idx  = (state == IDLE) ? (op_inv ? op_idx : req_idx) : lat_idx;
    assign cur_word = (state == IDLE) ? req_word : beat;
    assign cmp_tag  = (state == IDLE) ? req_tag : lat_tag;
    assign any_hit  = |w_hit;
    assign rr_adv   = (WAYS == 1) ? '0 : rr[req_idx] + WS'(1);

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        dcache_way #(
            .SETS(SETS), .LINE_WORDS(LINE_WORDS), .TW(TW), .IW(IDX), .WO(WO)
        ) u_way (
            .clk(clk), .rst(rst), .idx(cur_idx), .word(cur_word), .tag(cmp_tag),
            .hit(w_hit[g]), .rdata(w_rdata[g]), .line_valid(w_valid[g]),
            .line_dirty(w_dirty[g]), .line_tag(w_tag[g]),
            .fill_we(fill_we[g]), .fill_data(mem_rdata),
            .merge_we(merge_we[g]), .wmask(d_wmask), .wdata(d_wdata),
            .alloc(alloc[g]), .inv(inv[g])
        );
    end

    // Hit word and victim choice: lowest invalid way, else the set's rr way.
    always_comb begin
        hit_word  = '0;
        hit_way   = '0;
        vic_pick  = rr[req_idx];
        vic_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_hit[w]) begin
                hit_word = hit_word | w_rdata[w];
                hit_way  = WS'(w);
            end
            if (!w_valid[w] && !vic_found) begin
                vic_pick  = WS'(w);
                vic_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            beat    <= '0;
            lat_tag <= '0;
            lat_idx <= '0;
            victim  <= '0;
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else begin
            state   <= state_n;
            beat    <= beat_n;
            lat_tag <= lat_tag_n;
            lat_idx <= lat_idx_n;
            victim  <= victim_n;
            if (rr_we) rr[req_idx] <= rr_adv;
        end
    end

    always_comb begin
        state_n   = state;
        beat_n    = beat;
        lat_tag_n = lat_tag;
        lat_idx_n = lat_idx;
        victim_n  = victim;
        rr_we     = 1'b0;
        fill_we   = '0;
        merge_we  = '0;
        alloc     = '0;
        inv       = '0;
        ready     = 1'b0;
        d_rdata   = '0;
        mem_r     = 1'b0;
        mem_w     = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cache_err = (state != IDLE) && op_inv;
        hit_evt   = 1'b0;
        miss_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (op_inv) begin
                    if (w_valid[op_way] && w_dirty[op_way]) begin
                        state_n   = OPWB;
                        lat_idx_n = op_idx;
                        victim_n  = op_way;
                        beat_n    = '0;
                    end else begin
                        inv[op_way] = 1'b1;
                    end
                end else if (d_r && d_w) begin
                    cache_err = 1'b1;
                    ready     = 1'b1;
                end else if (d_r || d_w) begin
                    if (any_hit) begin
                        ready   = 1'b1;
                        hit_evt = 1'b1;
                        if (d_r) d_rdata = hit_word;
                        if (d_w) merge_we[hit_way] = 1'b1;
                    end else begin
                        lat_tag_n = req_tag;
                        lat_idx_n = req_idx;
                        victim_n  = vic_pick;
                        beat_n    = '0;
                        rr_we     = 1'b1;
                        miss_evt  = 1'b1;
                        state_n   = (w_valid[vic_pick] && w_dirty[vic_pick]) ? WBACK : FILL;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            WBACK, OPWB: begin
                mem_w     = 1'b1;
                mem_addr  = {w_tag[victim], lat_idx, beat, 2'b00};
                mem_wdata = w_rdata[victim];
                if (mem_ready) begin
                    if (beat == LAST) begin
                        beat_n = '0;
                        if (state == OPWB) begin
                            inv[victim] = 1'b1;
                            state_n     = IDLE;
                        end else begin
                            state_n = FILL;
                        end
                    end else begin
                        beat_n = beat + WO'(1);
                    end
                end
            end
            FILL: begin
                mem_r    = 1'b1;
                mem_addr = {lat_tag, lat_idx, beat, 2'b00};
                if (mem_ready) begin
                    fill_we[victim] = 1'b1;
                    if (beat == LAST) begin
                        alloc[victim] = 1'b1;
                        beat_n        = '0;
                        state_n       = IDLE;
                    end else begin
                        beat_n = beat + WO'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_evt && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            if (miss_evt && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`else
    logic unused_evt;
    assign unused_evt = hit_evt | miss_evt;
    assign hit_cnt    = '0;
    assign miss_cnt   = '0;
`endif

endmodule
